multicore_memory_arbiter: RTL and testbench

- Parametrised successor to the single-core RAM arbiter: serves CPUS cores, each with an I-port and a D-port, through one shared RAM.
- Round-robin fairness across cores; data has priority over instruction within a core.
- Broadcasts a one-cycle invalidate to all other cores on every completed data write, as the first step toward snooping coherence.
- Sits between the per-core caches and the ram model.

---
 rtl/cpu_types_pkg.sv | 33 +++
 rtl/rr_arbiter.sv | 32 +++
 rtl/multicore_memory_arbiter.sv | 169 ++++++++++++++++
 tb/tb_multicore_memory_arbiter.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_types_pkg.sv
// Shared types for the multicore memory arbiter: RAM handshake states,
// arbiter FSM states and the latched grant record.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE,
    BUSY,
    ACCESS,
    ERROR
  } ramstate_t;

  typedef enum logic {
    IDLE,
    REQ
  } arb_state_t;

  // Wide enough for the largest supported core count (8).
  localparam int CORE_IDX_W = 3;
  typedef logic [CORE_IDX_W-1:0] core_idx_t;

  typedef struct packed {
    core_idx_t core;
    logic      is_data;
    logic      is_write;
  } grant_t;

  function automatic core_idx_t next_core(input core_idx_t c, input int n);
    return (int'(c) + 1 >= n) ? '0 : core_idx_t'(int'(c) + 1);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first requester at or after ptr wins.
// The pointer register is owned by the instantiating module.
module rr_arbiter
  import cpu_types_pkg::*;
#(
  parameter int N = 2
) (
  input  logic [N-1:0] req,
  input  core_idx_t    ptr,
  output logic [N-1:0] gnt,
  output core_idx_t    idx
);

  logic found;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    // Outer loop walks priority order; inner loop keeps every select constant.
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        if (!found && req[j] && (j == (int'(ptr) + i) % N)) begin
          found  = 1'b1;
          gnt[j] = 1'b1;
          idx    = core_idx_t'(j);
        end
      end
    end
  end

endmodule

// File: rtl/multicore_memory_arbiter.sv
// Shares one RAM between CPUS cores (I and D port each), round-robin across
// cores, D over I within a core. Optional MEMCTRL_ERR_ABORT_EN adds merr abort.
module multicore_memory_arbiter
  import cpu_types_pkg::*;
#(
  parameter int CPUS      = 2,
  parameter int WORD_W    = 32,
  parameter int ERR_LIMIT = 8
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic [CPUS-1:0]        iREN,
  input  logic [CPUS-1:0]        dREN,
  input  logic [CPUS-1:0]        dWEN,
  input  logic [CPUS*WORD_W-1:0] iaddr,
  input  logic [CPUS*WORD_W-1:0] daddr,
  input  logic [CPUS*WORD_W-1:0] dstore,
  output logic [CPUS-1:0]        iwait,
  output logic [CPUS-1:0]        dwait,
  output logic [CPUS*WORD_W-1:0] iload,
  output logic [CPUS*WORD_W-1:0] dload,
  output logic [CPUS-1:0]        ccinv,
  output logic [CPUS*WORD_W-1:0] ccsnoopaddr,
  output logic                   ramREN,
  output logic                   ramWEN,
  output logic [WORD_W-1:0]      ramaddr,
  output logic [WORD_W-1:0]      ramstore,
  input  logic [WORD_W-1:0]      ramload,
  input  ramstate_t              ramstate
`ifdef MEMCTRL_ERR_ABORT_EN
  ,
  output logic [CPUS-1:0]        merr
`endif
);

  if (CPUS < 1 || CPUS > 8 || ERR_LIMIT < 1) begin : g_param_check
    $error("multicore_memory_arbiter: CPUS must be 1..8 and ERR_LIMIT >= 1");
  end

  arb_state_t        state_q, state_d;
  grant_t            grant_q, grant_d;
  core_idx_t         rr_q, rr_d, arb_idx;
  logic [CPUS-1:0]   pending, arb_gnt, core_oh;
  logic              sel_d, sel_w, live;
  logic              g_iren, g_dren, g_dwen;
  logic [WORD_W-1:0] g_iaddr, g_daddr, g_dstore;

  assign pending = iREN | dREN | dWEN;
  assign sel_d   = |(arb_gnt & (dREN | dWEN));
  assign sel_w   = |(arb_gnt & dWEN);
  assign iload   = {CPUS{ramload}};
  assign dload   = {CPUS{ramload}};

  rr_arbiter #(.N(CPUS)) u_rr (
    .req (pending),
    .ptr (rr_q),
    .gnt (arb_gnt),
    .idx (arb_idx)
  );

  // Live request signals of the latched grant; a drop means withdrawal.
  always_comb begin
    core_oh  = '0;
    g_iren   = 1'b0;
    g_dren   = 1'b0;
    g_dwen   = 1'b0;
    g_iaddr  = '0;
    g_daddr  = '0;
    g_dstore = '0;
    for (int c = 0; c < CPUS; c++) begin
      core_oh[c] = (grant_q.core == core_idx_t'(c));
      if (core_oh[c]) begin
        g_iren   = iREN[c];
        g_dren   = dREN[c];
        g_dwen   = dWEN[c];
        g_iaddr  = iaddr[c*WORD_W +: WORD_W];
        g_daddr  = daddr[c*WORD_W +: WORD_W];
        g_dstore = dstore[c*WORD_W +: WORD_W];
      end
    end
  end

  assign live = grant_q.is_write ? g_dwen : (grant_q.is_data ? g_dren : g_iren);

`ifdef MEMCTRL_ERR_ABORT_EN
  localparam int ERR_W = $clog2(ERR_LIMIT + 1);
  logic [ERR_W-1:0] err_cnt;
  logic             err_abort;

  assign err_abort = (ramstate == ERROR) && (err_cnt == ERR_W'(ERR_LIMIT - 1));

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      err_cnt <= '0;
    end else if (state_q == REQ && state_d == REQ && ramstate == ERROR) begin
      if (err_cnt != ERR_W'(ERR_LIMIT - 1)) err_cnt <= err_cnt + ERR_W'(1);
    end else begin
      err_cnt <= '0;
    end
  end
`endif

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    rr_d        = rr_q;
    iwait       = '1;
    dwait       = '1;
    ccinv       = '0;
    ccsnoopaddr = '0;
    ramREN      = 1'b0;
    ramWEN      = 1'b0;
    ramaddr     = '0;
    ramstore    = '0;
`ifdef MEMCTRL_ERR_ABORT_EN
    merr        = '0;
`endif
    case (state_q)
      IDLE: begin
        if (|pending) begin
          grant_d = '{core: arb_idx, is_data: sel_d, is_write: sel_w};
          state_d = REQ;
        end
      end
      REQ: begin
        if (!live) begin
          state_d = IDLE;
        end else begin
          ramREN   = !grant_q.is_write;
          ramWEN   = grant_q.is_write;
          ramaddr  = grant_q.is_data ? g_daddr : g_iaddr;
          ramstore = grant_q.is_write ? g_dstore : '0;
          if (ramstate == ACCESS) begin
            if (grant_q.is_data) dwait = ~core_oh;
            else                 iwait = ~core_oh;
            // Every other core drops its copy of the written line.
            if (grant_q.is_write) begin
              ccinv       = ~core_oh;
              ccsnoopaddr = {CPUS{g_daddr}};
            end
            rr_d    = next_core(grant_q.core, CPUS);
            state_d = IDLE;
          end
`ifdef MEMCTRL_ERR_ABORT_EN
          else if (err_abort) begin
            merr    = core_oh;
            rr_d    = next_core(grant_q.core, CPUS);
            state_d = IDLE;
          end
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      grant_q <= '0;
      rr_q    <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      rr_q    <= rr_d;
    end
  end

endmodule

// File: tb/tb_multicore_memory_arbiter.sv
// Bench for multicore_memory_arbiter: a 2-core instance with a latency-
// configurable RAM model and a 4-core instance for the rotation check.
module tb_multicore_memory_arbiter;
  import cpu_types_pkg::*;

  localparam logic [31:0] K = 32'hA5A5_0000;
  typedef logic [101:0] rec_t;  // {core2, is_data, is_write, inv2, addr, data, snoop}

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  rec_t        exp_q[$];
  logic [34:0] exp4_q[$];

  // ---------------- 2-core instance ----------------
  logic [1:0]  iren, dren, dwen, iwait, dwait, ccinv;
  logic [63:0] iaddr, daddr, dstore, iload, dload, ccsnoopaddr;
  logic        ramren, ramwen;
  logic [31:0] ramaddr, ramstore, ramload;
  ramstate_t   ramstate;
  int          lat = 0;
  int          acc_cnt = 0;
  logic        force_err = 1'b0;
`ifdef MEMCTRL_ERR_ABORT_EN
  logic [1:0]  merr;
  logic [3:0]  merr4;
`endif

  assign ramstate = force_err ? ERROR :
                    !(ramren | ramwen) ? FREE :
                    (acc_cnt >= lat) ? ACCESS : BUSY;
  assign ramload = ramaddr ^ K;
  always @(posedge clk) acc_cnt <= ((ramren | ramwen) && ramstate != ACCESS) ? acc_cnt + 1 : 0;

  multicore_memory_arbiter #(.CPUS(2), .WORD_W(32), .ERR_LIMIT(8)) dut (
    .CLK(clk), .RST(rst), .iREN(iren), .dREN(dren), .dWEN(dwen),
    .iaddr(iaddr), .daddr(daddr), .dstore(dstore),
    .iwait(iwait), .dwait(dwait), .iload(iload), .dload(dload),
    .ccinv(ccinv), .ccsnoopaddr(ccsnoopaddr),
    .ramREN(ramren), .ramWEN(ramwen), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate)
`ifdef MEMCTRL_ERR_ABORT_EN
    , .merr(merr)
`endif
  );

  // ---------------- 4-core instance ----------------
  logic [3:0]   iren4, dren4, dwen4, iwait4, dwait4, ccinv4;
  logic [127:0] iaddr4, daddr4, dstore4, iload4, dload4, ccsnoopaddr4;
  logic         ramren4, ramwen4;
  logic [31:0]  ramaddr4, ramstore4, ramload4;
  ramstate_t    ramstate4;

  assign ramstate4 = (ramren4 | ramwen4) ? ACCESS : FREE;
  assign ramload4  = ramaddr4 ^ K;

  multicore_memory_arbiter #(.CPUS(4), .WORD_W(32), .ERR_LIMIT(8)) dut4 (
    .CLK(clk), .RST(rst), .iREN(iren4), .dREN(dren4), .dWEN(dwen4),
    .iaddr(iaddr4), .daddr(daddr4), .dstore(dstore4),
    .iwait(iwait4), .dwait(dwait4), .iload(iload4), .dload(dload4),
    .ccinv(ccinv4), .ccsnoopaddr(ccsnoopaddr4),
    .ramREN(ramren4), .ramWEN(ramwen4), .ramaddr(ramaddr4), .ramstore(ramstore4),
    .ramload(ramload4), .ramstate(ramstate4)
`ifdef MEMCTRL_ERR_ABORT_EN
    , .merr(merr4)
`endif
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic rec_t mkrec(input int core, input logic d, input logic w, input logic [1:0] inv,
                                 input logic [31:0] addr, input logic [31:0] data, input logic [31:0] snoop);
    return {2'(core), d, w, inv, addr, data, snoop};
  endfunction

  task automatic push_rd(input int core, input logic d, input logic [31:0] addr);
    exp_q.push_back(mkrec(core, d, 1'b0, 2'b00, addr, addr ^ K, 32'h0));
  endtask

  task automatic push_wr(input int core, input logic [31:0] addr, input logic [31:0] data);
    exp_q.push_back(mkrec(core, 1'b1, 1'b1, (core == 0) ? 2'b10 : 2'b01, addr, data, addr));
  endtask

  // Scoreboard: every dropped wait is one completed transfer.
  always @(negedge clk) begin
    int   nlow;
    rec_t obs;
    logic w;
    if (!rst) begin
      nlow = 0;
      for (int c = 0; c < 2; c++) begin
        for (int p = 0; p < 2; p++) begin
          w = (p == 0) ? iwait[c] : dwait[c];
          if (w == 1'b0) begin
            nlow++;
            obs = mkrec(c, p[0], ramwen, ccinv, ramaddr,
                        ramwen ? ramstore : ((p == 1) ? dload[c*32 +: 32] : iload[c*32 +: 32]),
                        ccinv[1-c] ? ccsnoopaddr[(1-c)*32 +: 32] : 32'h0);
            if (exp_q.size() == 0) check("sb_unexpected", obs, '0);
            else                   check("sb_xfer", obs, exp_q.pop_front());
          end
        end
      end
      if (nlow > 1)  check("one_wait_low", nlow, 1);
      if (nlow == 0) check("inv_quiet", ccinv, 2'b00);
    end
  end

  always @(negedge clk) begin
    logic [34:0] obs4;
    if (!rst) begin
      for (int c = 0; c < 4; c++) begin
        if (dwait4[c] == 1'b0) begin
          obs4 = {3'(c), ramaddr4};
          if (exp4_q.size() == 0) check("sb4_unexpected", obs4, '0);
          else                    check("sb4_grant", obs4, exp4_q.pop_front());
          check("sb4_load", dload4[c*32 +: 32], (32'h1000 + 32'(c * 16)) ^ K);
        end
      end
    end
  end

  int irem[2];
  int drem[2];

  // Core driver: on completion either retire the request or issue the next address.
  task automatic serve(input int budget);
    logic [1:0] di, dd;
    int left;
    left = irem[0] + irem[1] + drem[0] + drem[1];
    for (int k = 0; k < budget && left != 0; k++) begin
      @(negedge clk);
      di = ~iwait & iren;
      dd = ~dwait & (dren | dwen);
      @(posedge clk);
      #1;
      for (int c = 0; c < 2; c++) begin
        if (di[c]) begin
          irem[c]--;
          if (irem[c] == 0) iren[c] = 1'b0;
          else              iaddr[c*32 +: 32] += 32'd4;
        end
        if (dd[c]) begin
          drem[c]--;
          if (drem[c] == 0) begin dren[c] = 1'b0; dwen[c] = 1'b0; end
          else              daddr[c*32 +: 32] += 32'd4;
        end
      end
      left = irem[0] + irem[1] + drem[0] + drem[1];
    end
    check("serve_done", left, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    iren = '0; dren = '0; dwen = '0; iaddr = '0; daddr = '0; dstore = '0;
    iren4 = '0; dren4 = '0; dwen4 = '0; iaddr4 = '0; daddr4 = '0; dstore4 = '0;
    irem = '{0, 0}; drem = '{0, 0};

    // Clock/reset block and reset values
    #2;
    check("rst_iwait", iwait, 2'b11);
    check("rst_dwait", dwait, 2'b11);
    check("rst_ccinv", ccinv, 2'b00);
    check("rst_ren", ramren, 1'b0);
    check("rst_wen", ramwen, 1'b0);
    check("rst_addr", ramaddr, 32'h0);
    check("rst_store", ramstore, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // 1: two I-requesters, one BUSY cycle per access, strict alternation
    lat = 1;
    iaddr = {32'h20, 32'h10};
    irem = '{2, 2};
    push_rd(0, 1'b0, 32'h10); push_rd(1, 1'b0, 32'h20);
    push_rd(0, 1'b0, 32'h14); push_rd(1, 1'b0, 32'h24);
    iren = 2'b11;
    serve(60);
    check("t1_drain", exp_q.size(), 0);

    // 2: D beats I within core0
    lat = 0;
    daddr[31:0] = 32'h40;
    iaddr[31:0] = 32'h80;
    irem = '{1, 0}; drem = '{1, 0};
    push_rd(0, 1'b1, 32'h40); push_rd(0, 1'b0, 32'h80);
    iren[0] = 1'b1; dren[0] = 1'b1;
    serve(40);
    check("t2_drain", exp_q.size(), 0);

    // 3: writes broadcast invalidate to the other core only
    daddr  = {32'h100, 32'h200};
    dstore = {32'hDEADBEEF, 32'h12345678};
    drem = '{1, 1};
    push_wr(1, 32'h100, 32'hDEADBEEF);
    push_wr(0, 32'h200, 32'h12345678);
    dwen = 2'b11;
    serve(40);
    check("t3_drain", exp_q.size(), 0);

    // 4: RAM stuck in ERROR for 20 cycles
    force_err = 1'b1;
    iaddr = {32'h400, 32'h300};
    iren = 2'b11;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      check("t4_waits_high", {iwait, dwait}, 4'hF);
`ifdef MEMCTRL_ERR_ABORT_EN
      if (k == 9)  check("t4_merr_first", merr, 2'b10);
      else if (k == 18) check("t4_merr_second", merr, 2'b01);
      else check("t4_merr_quiet", merr, 2'b00);
`endif
    end
    check("t4_hold_ren", ramren, 1'b1);
    check("t4_hold_addr", ramaddr, 32'h400);
    @(posedge clk);
    #1;
    irem = '{1, 1};
    push_rd(1, 1'b0, 32'h400); push_rd(0, 1'b0, 32'h300);
    force_err = 1'b0;
    serve(40);
    check("t4_drain", exp_q.size(), 0);

    // 5: async reset in the middle of a slow write
    lat = 5;
    daddr[63:32]  = 32'h500;
    dstore[63:32] = 32'hCAFEF00D;
    dwen[1] = 1'b1;
    @(posedge clk);
    #1;
    check("t5_req_wen", ramwen, 1'b1);
    check("t5_req_addr", ramaddr, 32'h500);
    #3;
    rst = 1'b1;
    #1;
    check("t5_async_wen", ramwen, 1'b0);
    check("t5_async_ren", ramren, 1'b0);
    check("t5_async_waits", {iwait, dwait}, 4'hF);
    dwen = '0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    lat = 0;
    iaddr = {32'h700, 32'h600};
    irem = '{1, 1};
    push_rd(0, 1'b0, 32'h600); push_rd(1, 1'b0, 32'h700);
    iren = 2'b11;
    serve(40);
    check("t5_drain", exp_q.size(), 0);

    // 6: four cores hammering dREN rotate 0,1,2,3,0,...
    daddr4 = {32'h1030, 32'h1020, 32'h1010, 32'h1000};
    for (int k = 0; k < 8; k++) exp4_q.push_back({3'(k % 4), 32'h1000 + 32'((k % 4) * 16)});
    dren4 = 4'hF;
    for (int k = 0; k < 100 && exp4_q.size() != 0; k++) begin
      @(posedge clk);
      #1;
    end
    dren4 = '0;
    check("t6_drain", exp4_q.size(), 0);

    repeat (3) @(posedge clk);
    check("final_q", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
